// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle for the ppc2simulink register bank.
// Signal names and big-endian bit numbering follow the PPC OPB convention.
interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB register bank: N_REGS byte-writable 32-bit registers driven to user logic,
// with readback, per-register write strobes and optional LSW/MSW atomic pairs.
//
// state   | meaning
// IDLE    | waiting for a bus hit
// ACK     | Sl_xferAck high for one cycle; new hits are ignored
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5",
  parameter int          N_REGS       = 4,
  parameter int          ATOMIC_PAIRS = 0,
  parameter logic [31:0] RESET_VAL    = 32'h0000_0000
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [N_REGS*32-1:0]       user_data_out,
  output logic [N_REGS-1:0]          user_wr_strobe
);

  localparam int N_SHADOW = (N_REGS + 1) / 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [31:0]       regs_q   [N_REGS];
  logic [31:0]       regs_d   [N_REGS];
  logic [31:0]       shadow_q [N_SHADOW];
  logic [31:0]       shadow_d [N_SHADOW];
  logic [31:0]       rdata_q, rdata_d;
  logic [N_REGS-1:0] strobe_q, strobe_d;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] offset;
  logic [29:0] word_idx;
  logic [3:0]  be_user;
  logic        in_range;
  logic        hit;

  assign addr     = opb.OPB_ABus;
  assign wdata    = opb.OPB_DBus;
  // BE[0] qualifies the most significant byte (DBus[0:7]).
  assign be_user  = {opb.OPB_BE[0], opb.OPB_BE[1], opb.OPB_BE[2], opb.OPB_BE[3]};
  assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign hit      = opb.OPB_select && in_range && (state_q == ST_IDLE);
  assign offset   = addr - C_BASEADDR;
  assign word_idx = offset[31:2];

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_d  = hit ? ST_ACK : ST_IDLE;
    regs_d   = regs_q;
    shadow_d = shadow_q;
    rdata_d  = '0;
    strobe_d = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (hit && (word_idx == 30'(i))) begin
        if (opb.OPB_RNW) begin
          rdata_d = regs_q[i];
        end else if ((ATOMIC_PAIRS != 0) && ((i % 2) == 0)) begin
          shadow_d[i/2] = be_merge(shadow_q[i/2], wdata, be_user);
        end else begin
          regs_d[i]   = be_merge(regs_q[i], wdata, be_user);
          strobe_d[i] = 1'b1;
          // MSW write commits the pair's LSW shadow in the same edge.
          if (ATOMIC_PAIRS != 0) begin
            regs_d[i - (i % 2)]   = shadow_q[i/2];
            strobe_d[i - (i % 2)] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q  <= ST_IDLE;
      rdata_q  <= '0;
      strobe_q <= '0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= RESET_VAL;
      for (int j = 0; j < N_SHADOW; j++) shadow_q[j] <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
      regs_q   <= regs_d;
      shadow_q <= shadow_d;
    end
  end

  assign opb.Sl_xferAck = (state_q == ST_ACK);
  assign opb.Sl_DBus    = rdata_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs_q[g];
  end
  assign user_wr_strobe = strobe_q;

  logic unused_ok;
  assign unused_ok = ^{opb.OPB_seqAddr, offset[1:0], (C_OPB_AWIDTH == 32),
                       (C_OPB_DWIDTH == 32), |C_FAMILY};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: a plain bank and an atomic-pair bank at a
// non-zero base, both checked against a word-level model of the register map.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] RV_N   = 32'hA5A5_0F0F;
  localparam logic [31:0] RV_A   = 32'h1234_5678;
  localparam logic [31:0] BASE_N = 32'h0000_0000;
  localparam logic [31:0] HIGH_N = 32'h0000_00FF;
  localparam logic [31:0] BASE_A = 32'h0000_1000;
  localparam logic [31:0] HIGH_A = 32'h0000_101F;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] uo_n, uo_a;
  logic [3:0]   st_n, st_a;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mdl_n [4];
  logic [31:0] mdl_a [4];
  logic [31:0] shd_a [2];

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink_if bus_n ();
  opb_register_bank_ppc2simulink_if bus_a ();

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(BASE_N), .C_HIGHADDR(HIGH_N), .N_REGS(4),
    .ATOMIC_PAIRS(0), .RESET_VAL(RV_N)
  ) dut_n (
    .OPB_Clk(clk), .OPB_Rst(rst), .opb(bus_n),
    .user_data_out(uo_n), .user_wr_strobe(st_n)
  );

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(BASE_A), .C_HIGHADDR(HIGH_A), .N_REGS(4),
    .ATOMIC_PAIRS(1), .RESET_VAL(RV_A)
  ) dut_a (
    .OPB_Clk(clk), .OPB_Rst(rst), .opb(bus_a),
    .user_data_out(uo_a), .user_wr_strobe(st_a)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input bit atm);
    return atm ? bus_a.Sl_xferAck : bus_n.Sl_xferAck;
  endfunction

  function automatic logic [31:0] rd_of(input bit atm);
    return atm ? bus_a.Sl_DBus : bus_n.Sl_DBus;
  endfunction

  function automatic logic [3:0] stb_of(input bit atm);
    return atm ? st_a : st_n;
  endfunction

  function automatic logic [127:0] uo_of(input bit atm);
    return atm ? uo_a : uo_n;
  endfunction

  function automatic logic [127:0] exp_uo(input bit atm);
    if (atm) return {mdl_a[3], mdl_a[2], mdl_a[1], mdl_a[0]};
    return {mdl_n[3], mdl_n[2], mdl_n[1], mdl_n[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mdl_n[i] = RV_N;
      mdl_a[i] = RV_A;
    end
    shd_a[0] = '0;
    shd_a[1] = '0;
  endtask

  // Word-level view of one transaction: which register/shadow changes and what is read.
  task automatic model_xfer(input bit atm, input logic [31:0] addr, input bit rnw,
                            input logic [0:3] be, input logic [31:0] wd,
                            output bit hit, output logic [31:0] rd, output logic [3:0] stb);
    logic [31:0] base, high, mask, merged;
    int idx;
    base = atm ? BASE_A : BASE_N;
    high = atm ? HIGH_A : HIGH_N;
    hit  = (addr >= base) && (addr <= high);
    rd   = '0;
    stb  = '0;
    if (!hit) return;
    idx = int'((addr - base) / 4);
    if (idx >= 4) return;
    mask = {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
    if (rnw) begin
      rd = atm ? mdl_a[idx] : mdl_n[idx];
    end else if (!atm) begin
      mdl_n[idx] = (mdl_n[idx] & ~mask) | (wd & mask);
      stb = 4'(1 << idx);
    end else if (idx % 2 == 0) begin
      shd_a[idx/2] = (shd_a[idx/2] & ~mask) | (wd & mask);
    end else begin
      merged       = (mdl_a[idx] & ~mask) | (wd & mask);
      mdl_a[idx-1] = shd_a[idx/2];
      mdl_a[idx]   = merged;
      stb = 4'(3 << (idx - 1));
    end
  endtask

  task automatic drive(input bit atm, input logic [31:0] addr, input bit rnw,
                       input logic [0:3] be, input logic [31:0] wd, input bit sel);
    if (atm) begin
      bus_a.OPB_ABus = addr; bus_a.OPB_RNW = rnw; bus_a.OPB_BE = be;
      bus_a.OPB_DBus = wd;   bus_a.OPB_select = sel;
    end else begin
      bus_n.OPB_ABus = addr; bus_n.OPB_RNW = rnw; bus_n.OPB_BE = be;
      bus_n.OPB_DBus = wd;   bus_n.OPB_select = sel;
    end
  endtask

  task automatic xfer(input bit atm, input logic [31:0] addr, input bit rnw,
                      input logic [0:3] be, input logic [31:0] wd);
    bit          hit;
    logic [31:0] erd;
    logic [3:0]  estb;
    @(negedge clk);
    drive(atm, addr, rnw, be, wd, 1'b1);
    @(posedge clk);
    #1;
    bus_n.OPB_select = 1'b0;
    bus_a.OPB_select = 1'b0;
    model_xfer(atm, addr, rnw, be, wd, hit, erd, estb);
    chk("ack", 128'(ack_of(atm)), 128'(hit));
    chk("rdata", 128'(rd_of(atm)), 128'(erd));
    chk("strobe", 128'(stb_of(atm)), 128'(estb));
    chk("user_out", uo_of(atm), exp_uo(atm));
    @(posedge clk);
    #1;
    chk("ack_one_cycle", 128'(ack_of(atm)), 128'(0));
    chk("strobe_one_cycle", 128'(stb_of(atm)), 128'(0));
    chk("rdata_idle", 128'(rd_of(atm)), 128'(0));
  endtask

  task automatic reset_during_write(input bit atm, input logic [31:0] addr);
    @(negedge clk);
    rst = 1'b1;
    drive(atm, addr, 1'b0, 4'b1111, 32'h0BAD_F00D, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_n.OPB_select = 1'b0;
    bus_a.OPB_select = 1'b0;
    model_reset();
    chk("rst_wr_ack", 128'(ack_of(atm)), 128'(0));
    chk("rst_wr_regs", uo_of(atm), exp_uo(atm));
    @(posedge clk);
    #1;
    chk("rst_wr_ack_late", 128'(ack_of(atm)), 128'(0));
    chk("rst_wr_strobe", 128'(stb_of(atm)), 128'(0));
  endtask

  initial begin
    logic [0:3]  be_t;
    logic [31:0] addr_t;
    bit          atm_t;

    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, '0, 1'b0, '0, '0, 1'b0);
    bus_n.OPB_seqAddr = 1'b0;
    bus_a.OPB_seqAddr = 1'b0;
    model_reset();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack_n", 128'(bus_n.Sl_xferAck), 128'(0));
    chk("reset_dbus_n", 128'(bus_n.Sl_DBus), 128'(0));
    chk("reset_strobe_n", 128'(st_n), 128'(0));
    chk("reset_out_n", uo_n, {4{RV_N}});
    chk("reset_out_a", uo_a, {4{RV_A}});
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) xfer(1'b0, BASE_N + 32'(4*i), 1'b1, 4'b1111, '0);

    xfer(1'b0, BASE_N + 32'h8, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    chk("deadbeef_out", 128'(uo_n[95:64]), 128'(32'hDEAD_BEEF));
    xfer(1'b0, BASE_N + 32'h8, 1'b1, 4'b1111, '0);

    xfer(1'b0, BASE_N + 32'h4, 1'b0, 4'b1111, 32'hAABB_CCDD);
    be_t = '0;
    be_t[2] = 1'b1;
    xfer(1'b0, BASE_N + 32'h5, 1'b0, be_t, 32'h1122_3344);
    chk("byte_enable", 128'(uo_n[63:32]), 128'(32'hAABB_33DD));

    xfer(1'b0, BASE_N, 1'b0, 4'b0000, 32'hFFFF_FFFF);

    xfer(1'b0, BASE_N + 32'h10, 1'b0, 4'b1111, 32'h5555_AAAA);
    xfer(1'b0, BASE_N + 32'h10, 1'b1, 4'b1111, '0);
    xfer(1'b0, HIGH_N + 32'h1, 1'b1, 4'b1111, '0);

    @(negedge clk);
    drive(1'b0, HIGH_N + 32'h1, 1'b0, 4'b1111, 32'h1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("beyond_high_no_ack", 128'(bus_n.Sl_xferAck), 128'(0));
    end
    bus_n.OPB_select = 1'b0;

    xfer(1'b1, BASE_A + 32'hC, 1'b0, 4'b1111, 32'h9);
    xfer(1'b1, BASE_A, 1'b0, 4'b1111, 32'h5);
    chk("lsw_held", 128'(uo_a[31:0]), 128'(RV_A));
    xfer(1'b1, BASE_A + 32'h4, 1'b0, 4'b1111, 32'h7);
    chk("pair_commit", 128'(uo_a[63:0]), 128'({32'h7, 32'h5}));
    xfer(1'b1, BASE_A, 1'b0, 4'b1111, 32'hFF);
    xfer(1'b1, BASE_A, 1'b1, 4'b1111, '0);
    xfer(1'b1, BASE_A + 32'h10, 1'b1, 4'b1111, '0);
    xfer(1'b1, HIGH_A + 32'h1, 1'b0, 4'b1111, 32'h3);

    for (int n = 0; n < 80; n++) begin
      atm_t  = 1'($urandom_range(0, 1));
      addr_t = (atm_t ? BASE_A : BASE_N) + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr_t = (atm_t ? HIGH_A : HIGH_N) + 32'($urandom_range(1, 64));
      be_t = 4'($urandom);
      xfer(atm_t, addr_t, 1'($urandom_range(0, 1)), be_t, $urandom);
    end

    reset_during_write(1'b0, BASE_N + 32'h8);
    reset_during_write(1'b1, BASE_A + 32'h4);
    xfer(1'b1, BASE_A + 32'h4, 1'b0, 4'b1111, 32'hCAFE_0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
